// File: rtl/predictor_update_ctrl_if.sv
// Bundle for predictor_update_ctrl.
//   master : EX resolve / IF lookup side (drives requests, observes status and write port)
//   slave  : predictor_update_ctrl
//   upd_*          : branch-outcome update handshake
//   lookup_*       : IF lookup index and hazard flag
//   predictor_*    : read/write port toward basic_predictor_2b
//   fifo_count     : entries currently pending
interface predictor_update_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
);
  logic                    upd_valid;
  logic [ADDR_WIDTH-1:0]   upd_index;
  logic                    upd_taken;
  logic                    upd_ready;
  logic                    upd_hold;
  logic                    lookup_valid;
  logic [ADDR_WIDTH-1:0]   lookup_index;
  logic                    lookup_hazard;
  logic [ADDR_WIDTH-1:0]   predictor_raddr;
  logic [ADDR_WIDTH-1:0]   predictor_waddr;
  logic                    predictor_wen;
  logic                    branch_taken_ex;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output upd_valid, upd_index, upd_taken, upd_hold, lookup_valid, lookup_index,
    input  upd_ready, lookup_hazard, predictor_raddr, predictor_waddr, predictor_wen,
           branch_taken_ex, fifo_count
  );

  modport slave (
    input  upd_valid, upd_index, upd_taken, upd_hold, lookup_valid, lookup_index,
    output upd_ready, lookup_hazard, predictor_raddr, predictor_waddr, predictor_wen,
           branch_taken_ex, fifo_count
  );
endinterface

// File: rtl/predictor_update_ctrl.sv
// predictor_update_ctrl
// Buffers EX-stage branch-outcome updates in a small FIFO and drains them, one per cycle,
// into the 2-bit predictor table write port. A drain is deferred while the IF lookup hits
// the head entry's index, for at most MAX_DEFER consecutive cycles before a forced write.
// Ports:
//   cpu_clk : core clock
//   cpu_rst : asynchronous active-high reset
//   bus     : slave side of predictor_update_ctrl_if (update handshake, lookup, table port)
module predictor_update_ctrl #(
  parameter int unsigned ENTRY_NUM  = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(ENTRY_NUM),
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_DEFER  = 3
) (
  input logic                    cpu_clk,
  input logic                    cpu_rst,
  predictor_update_ctrl_if.slave bus
);
  localparam int unsigned AW_F = $clog2(DEPTH);
  localparam int unsigned CW   = AW_F + 1;
  localparam int unsigned DW   = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;

  typedef enum logic [1:0] {StIdle, StDrain, StDefer, StHold} state_e;

  logic [ADDR_WIDTH-1:0] idx_mem_q [DEPTH];
  logic [DEPTH-1:0]      taken_mem_q;

  logic [AW_F-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DW-1:0]         defer_cnt_q, defer_cnt_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  taken_q, taken_d;
  state_e                state_q, state_d;

  logic                  ready, push, pop, defer, conflict, forced, hit;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic                  head_taken;

  assign ready      = !cpu_rst && (count_q < CW'(DEPTH));
  assign push       = bus.upd_valid && ready;
  assign head_idx   = idx_mem_q[rptr_q];
  assign head_taken = taken_mem_q[rptr_q];
  assign conflict   = bus.lookup_valid && (bus.lookup_index == head_idx);
  assign forced     = (defer_cnt_q == DW'(MAX_DEFER));
  // Hold outranks a forced write: nothing leaves the FIFO while frozen.
  assign pop        = (count_q != '0) && !bus.upd_hold && (!conflict || forced);
  assign defer      = (count_q != '0) && !bus.upd_hold && conflict && !forced;

  // Hazard covers queued entries plus the write currently on the table port.
  always_comb begin
    logic [AW_F-1:0] offs;
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = AW_F'(i) - rptr_q;
      if (({1'b0, offs} < count_q) && (idx_mem_q[i] == bus.lookup_index)) begin
        hit = 1'b1;
      end
    end
    if (wen_q && (waddr_q == bus.lookup_index)) begin
      hit = 1'b1;
    end
  end

  always_comb begin
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    defer_cnt_d = defer_cnt_q;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    taken_d     = taken_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d      = rptr_q + 1'b1;
      wen_d       = 1'b1;
      waddr_d     = head_idx;
      taken_d     = head_taken;
      defer_cnt_d = '0;
    end else if (defer) begin
      defer_cnt_d = defer_cnt_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State records what the controller did at the last edge; IDLE iff the FIFO is empty.
  always_comb begin
    if (count_d == '0) begin
      state_d = StIdle;
    end else if (bus.upd_hold) begin
      state_d = StHold;
    end else if (defer) begin
      state_d = StDefer;
    end else begin
      state_d = StDrain;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      defer_cnt_q <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      taken_q     <= 1'b0;
      state_q     <= StIdle;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      defer_cnt_q <= defer_cnt_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      taken_q     <= taken_d;
      state_q     <= state_d;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      idx_mem_q[wptr_q]   <= bus.upd_index;
      taken_mem_q[wptr_q] <= bus.upd_taken;
    end
  end

  assign bus.upd_ready       = ready;
  assign bus.lookup_hazard   = bus.lookup_valid && hit;
  assign bus.predictor_raddr = bus.lookup_index;
  assign bus.predictor_waddr = waddr_q;
  assign bus.predictor_wen   = wen_q;
  assign bus.branch_taken_ex = taken_q;
  assign bus.fifo_count      = count_q;

  idle_matches_empty: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    (state_q == StIdle) == (count_q == '0));
endmodule

// File: tb/tb_predictor_update_ctrl.sv
module tb_predictor_update_ctrl;
  localparam int DEPTH     = 4;
  localparam int MAX_DEFER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  predictor_update_ctrl_if #(.ADDR_WIDTH(8), .DEPTH(DEPTH)) bus ();

  predictor_update_ctrl #(
    .ENTRY_NUM (256),
    .ADDR_WIDTH(8),
    .DEPTH     (DEPTH),
    .MAX_DEFER (MAX_DEFER)
  ) dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit [1:0] sat(input bit [1:0] c, input bit t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // ---------------- reference model (queue of pending updates) ----------------
  typedef struct {
    logic [7:0] idx;
    logic       taken;
  } upd_t;

  upd_t       q[$];
  bit         m_wen   = 1'b0;
  bit [7:0]   m_waddr = '0;
  bit         m_taken = 1'b0;
  int         m_defer = 0;
  bit [1:0]   ref_tbl [256];
  bit [1:0]   dut_tbl [256];

  always @(posedge clk or posedge rst) begin : model
    bit   do_push;
    bit   clash;
    upd_t e;
    if (rst) begin
      q.delete();
      m_wen   = 1'b0;
      m_waddr = '0;
      m_taken = 1'b0;
      m_defer = 0;
    end else begin
      do_push = bus.upd_valid && (q.size() < DEPTH);
      clash   = (q.size() > 0) && bus.lookup_valid && (bus.lookup_index == q[0].idx);
      if ((q.size() > 0) && !bus.upd_hold && (!clash || m_defer == MAX_DEFER)) begin
        e       = q.pop_front();
        m_wen   = 1'b1;
        m_waddr = e.idx;
        m_taken = e.taken;
        m_defer = 0;
        ref_tbl[e.idx] = sat(ref_tbl[e.idx], e.taken);
      end else begin
        m_wen = 1'b0;
        if ((q.size() > 0) && !bus.upd_hold && clash) m_defer++;
      end
      if (do_push) begin
        e.idx   = bus.upd_index;
        e.taken = bus.upd_taken;
        q.push_back(e);
      end
    end
  end

  // Table fed by the DUT write port; a write lands at the edge where wen is seen high.
  always @(posedge clk) begin
    if (bus.predictor_wen) begin
      dut_tbl[bus.predictor_waddr] = sat(dut_tbl[bus.predictor_waddr], bus.branch_taken_ex);
    end
  end

  always @(posedge clk) begin : compare
    bit hz;
    #2;
    hz = 1'b0;
    foreach (q[i]) if (q[i].idx == bus.lookup_index) hz = 1'b1;
    if (m_wen && (m_waddr == bus.lookup_index)) hz = 1'b1;
    hz = hz && bus.lookup_valid;
    chk("m_wen", bus.predictor_wen, m_wen);
    chk("m_count", bus.fifo_count, q.size());
    chk("m_ready", bus.upd_ready, !rst && (q.size() < DEPTH));
    chk("m_hazard", bus.lookup_hazard, hz);
    chk("m_raddr", bus.predictor_raddr, bus.lookup_index);
    if (m_wen) begin
      chk("m_waddr", bus.predictor_waddr, m_waddr);
      chk("m_taken", bus.branch_taken_ex, m_taken);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int  accepted;
    int  budget;
    int  nmis;
    bit  rdy;
    bit  found;

    bus.upd_valid    = 1'b0;
    bus.upd_index    = '0;
    bus.upd_taken    = 1'b0;
    bus.upd_hold     = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.lookup_index = '0;

    cyc(2);
    chk("rst_wen", bus.predictor_wen, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_waddr", bus.predictor_waddr, 0);
    rst = 1'b0;
    cyc(1);
    chk("ready_after_rst", bus.upd_ready, 1);

    // 1: single update, latency
    bus.upd_valid = 1'b1; bus.upd_index = 8'd5; bus.upd_taken = 1'b1;
    cyc(1);
    chk("t1_count_after_push", bus.fifo_count, 1);
    chk("t1_no_wen_yet", bus.predictor_wen, 0);
    bus.upd_valid = 1'b0;
    cyc(1);
    chk("t1_wen", bus.predictor_wen, 1);
    chk("t1_waddr", bus.predictor_waddr, 5);
    chk("t1_taken", bus.branch_taken_ex, 1);
    chk("t1_count", bus.fifo_count, 0);
    cyc(1);
    chk("t1_table5", dut_tbl[5], 1);
    chk("t1_wen_pulse", bus.predictor_wen, 0);

    // 2: fill under hold, overflow attempt ignored, ordered drain
    bus.upd_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.upd_valid = 1'b1; bus.upd_index = 8'(10 + k); bus.upd_taken = k[0];
      cyc(1);
    end
    chk("t2_count_full", bus.fifo_count, 4);
    chk("t2_ready_full", bus.upd_ready, 0);
    bus.upd_index = 8'd99;
    cyc(1);
    chk("t2_push_ignored", bus.fifo_count, 4);
    bus.upd_valid = 1'b0; bus.upd_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("t2_wen", bus.predictor_wen, 1);
      chk("t2_order", bus.predictor_waddr, 10 + k);
      chk("t2_taken", bus.branch_taken_ex, k & 1);
    end
    cyc(1);
    chk("t2_drained", bus.fifo_count, 0);

    // 3: deferred drain bounded by MAX_DEFER
    bus.upd_valid = 1'b1; bus.upd_index = 8'd9; bus.upd_taken = 1'b1;
    bus.lookup_valid = 1'b1; bus.lookup_index = 8'd9;
    cyc(1);
    bus.upd_valid = 1'b0;
    chk("t3_hazard", bus.lookup_hazard, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("t3_deferred", bus.predictor_wen, 0);
    end
    cyc(1);
    chk("t3_forced_wen", bus.predictor_wen, 1);
    chk("t3_forced_addr", bus.predictor_waddr, 9);
    bus.lookup_valid = 1'b0;
    cyc(1);

    // 4: hazard on an entry queued behind another
    bus.upd_hold = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_index = 8'd2; bus.upd_taken = 1'b0;
    cyc(1);
    bus.upd_index = 8'd7; bus.upd_taken = 1'b1;
    cyc(1);
    bus.upd_valid = 1'b0; bus.upd_hold = 1'b0;
    bus.lookup_valid = 1'b1; bus.lookup_index = 8'd7;
    #1;
    chk("t4_hazard_queued", bus.lookup_hazard, 1);
    found = 1'b0;
    for (int n = 0; n < 12 && !found; n++) begin
      cyc(1);
      if (bus.predictor_wen && bus.predictor_waddr == 8'd7) found = 1'b1;
    end
    chk("t4_write_seen", found, 1);
    chk("t4_hazard_in_wen", bus.lookup_hazard, 1);
    cyc(1);
    chk("t4_hazard_clear", bus.lookup_hazard, 0);
    bus.lookup_valid = 1'b0;

    // 5: push+pop in one cycle, then random traffic
    bus.upd_hold = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_index = 8'd20; bus.upd_taken = 1'b1;
    cyc(1);
    bus.upd_index = 8'd21; bus.upd_taken = 1'b0;
    cyc(1);
    bus.upd_index = 8'd22; bus.upd_taken = 1'b1; bus.upd_hold = 1'b0;
    cyc(1);
    chk("t5_count_steady", bus.fifo_count, 2);
    chk("t5_pop_addr", bus.predictor_waddr, 20);
    bus.upd_valid = 1'b0;
    cyc(3);

    accepted = 0; budget = 0; rdy = 1'b1;
    while (accepted < 16 && budget < 200) begin
      if (rdy) begin
        bus.upd_valid = 1'b1;
        bus.upd_index = 8'($urandom_range(0, 7));
        bus.upd_taken = 1'($urandom_range(0, 1));
      end
      bus.lookup_valid = 1'($urandom_range(0, 1));
      bus.lookup_index = 8'($urandom_range(0, 7));
      bus.upd_hold     = ($urandom_range(0, 3) == 0);
      rdy = bus.upd_ready;
      cyc(1);
      if (rdy) accepted++;
      budget++;
    end
    chk("t5_accepted", accepted, 16);
    bus.upd_valid = 1'b0; bus.upd_hold = 1'b0; bus.lookup_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      cyc(1);
      if (bus.fifo_count == 0 && !bus.predictor_wen) found = 1'b1;
    end
    chk("t5_drain_done", found, 1);
    nmis = 0;
    for (int i = 0; i < 256; i++) if (dut_tbl[i] != ref_tbl[i]) nmis++;
    chk("t5_table_mismatches", nmis, 0);

    // 6: async reset mid-drain
    bus.upd_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.upd_valid = 1'b1; bus.upd_index = 8'(40 + k); bus.upd_taken = 1'b1;
      cyc(1);
    end
    bus.upd_valid = 1'b0; bus.upd_hold = 1'b0;
    cyc(1);
    chk("t6_count_mid", bus.fifo_count, 3);
    chk("t6_wen_mid", bus.predictor_wen, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_wen_async", bus.predictor_wen, 0);
    chk("t6_count_async", bus.fifo_count, 0);
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("t6_no_write", bus.predictor_wen, 0);
    end

    cyc(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
